rom_wr_packer: RTL and testbench

- Sits between the hps_io ioctl download port and the ddram controller write side.
- Collects consecutive 16-bit ROM words into a 64-bit DDR word, swapping bytes so the big-endian ROM lands in byte order.
- Issues each 64-bit word to ddram over a toggle req/ack handshake, with byte enables.
- Drives ioctl_wait to throttle the HPS, flushes the last partial word at download end, and reports the loaded ROM size.

---
 rtl/rom_wr_packer.sv | 194 +++++++++++++++++++
 tb/tb_rom_wr_packer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_wr_packer.sv
// Packs 16-bit ioctl ROM words into 64-bit ddram writes (toggle req/ack) with byte enables.
// Latency: a write that completes a 64-bit word is presented on wr_req one cycle later when ddram is idle.
// Backpressure: ioctl_wait rises while a completed word waits on an outstanding write or a word sits in hold.
//
// Ports:
//   clk_sys, reset_n                        clock, async active-low reset
//   ioctl_download/wr/addr/data, ioctl_wait  hps_io download side (addr is a byte address, always even)
//   wr_addr/wr_data/wr_be/wr_req, wr_ack     ddram write side, one outstanding write at most
//   rom_size                                 highest written byte address + 2 for this download
//   busy                                     download active or data not yet acknowledged by ddram
module rom_wr_packer #(
  parameter int AW   = 25,
  parameter bit SWAP = 1'b1
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [15:0]   ioctl_data,
  output logic          ioctl_wait,
  output logic [AW-4:0] wr_addr,
  output logic [63:0]   wr_data,
  output logic [7:0]    wr_be,
  output logic          wr_req,
  input  logic          wr_ack,
  output logic [AW-1:0] rom_size,
  output logic          busy
);

  // Place a lane-ordered 16-bit word into its slot of the 64-bit word.
  function automatic logic [63:0] f_place(input logic [15:0] word, input logic [1:0] lane);
    return {48'd0, word} << {lane, 4'd0};
  endfunction

  function automatic logic [7:0] f_be(input logic [1:0] lane);
    return 8'h03 << {lane, 1'b0};
  endfunction

  // Assembly buffer, hold register and issued-write registers
  logic [AW-4:0] r_asm_addr, n_asm_addr;
  logic [63:0]   r_asm_data, n_asm_data;
  logic [7:0]    r_asm_be,   n_asm_be;
  logic          r_commit,   n_commit;
  logic          r_hold_vld, n_hold_vld;
  logic [AW-4:0] r_hold_addr, n_hold_addr;
  logic [1:0]    r_hold_lane, n_hold_lane;
  logic [15:0]   r_hold_word, n_hold_word;
  logic [AW-4:0] r_wr_addr,  n_wr_addr;
  logic [63:0]   r_wr_data,  n_wr_data;
  logic [7:0]    r_wr_be,    n_wr_be;
  logic          r_wr_req,   n_wr_req;
  logic [AW-1:0] r_rom_size, n_rom_size;
  logic          r_wait,     n_wait;
  logic          r_busy,     n_busy;
  logic          r_dl_d;

  logic [1:0]    w_lane;
  logic [AW-4:0] w_word_addr;
  logic [15:0]   w_word;
  logic [AW-1:0] w_addr_p2;
  logic          w_accept;
  logic          w_idle;
  logic          w_dl_rise;
  logic          w_issue;
  logic          w_hold_merge;
  logic          w_unused;

  assign w_lane      = ioctl_addr[2:1];
  assign w_word_addr = ioctl_addr[AW-1:3];
  // Lane order: lower byte of the 16-bit slot is the lower DDR byte address.
  assign w_word      = SWAP ? {ioctl_data[7:0], ioctl_data[15:8]} : ioctl_data;
  assign w_addr_p2   = ioctl_addr + AW'(2);
  // Writes arriving during a stall are protocol violations and are dropped.
  assign w_accept    = ioctl_wr & ~r_wait;
  assign w_idle      = (r_wr_req == wr_ack);
  assign w_dl_rise   = ioctl_download & ~r_dl_d;
  assign w_issue     = r_commit & w_idle & ~w_dl_rise;
  // The held word only moves in once the previous buffer has left.
  assign w_hold_merge = r_hold_vld & ~r_commit & (r_asm_be == 8'd0) & ~w_dl_rise;
  assign w_unused    = ioctl_addr[0];

  always_comb begin
    n_asm_addr  = r_asm_addr;
    n_asm_data  = r_asm_data;
    n_asm_be    = r_asm_be;
    n_commit    = r_commit;
    n_hold_vld  = r_hold_vld;
    n_hold_addr = r_hold_addr;
    n_hold_lane = r_hold_lane;
    n_hold_word = r_hold_word;
    n_wr_addr   = r_wr_addr;
    n_wr_data   = r_wr_data;
    n_wr_be     = r_wr_be;
    n_wr_req    = r_wr_req;
    n_rom_size  = r_rom_size;

    if (w_dl_rise) begin
      n_asm_addr = '0;
      n_asm_data = '0;
      n_asm_be   = '0;
      n_commit   = 1'b0;
      n_hold_vld = 1'b0;
      n_rom_size = '0;
    end

    if (w_issue) begin
      n_wr_addr  = r_asm_addr;
      n_wr_data  = r_asm_data;
      n_wr_be    = r_asm_be;
      n_wr_req   = ~r_wr_req;
      n_asm_data = '0;
      n_asm_be   = '0;
      n_commit   = 1'b0;
    end else if (w_hold_merge) begin
      n_asm_addr = r_hold_addr;
      n_asm_data = f_place(r_hold_word, r_hold_lane);
      n_asm_be   = f_be(r_hold_lane);
      n_hold_vld = 1'b0;
    end

    // Outside a download any leftover partial word is flushed.
    if (!ioctl_download && (r_asm_be != 8'd0) && !r_commit)
      n_commit = 1'b1;

    if (w_accept) begin
      if (w_addr_p2 > n_rom_size)
        n_rom_size = w_addr_p2;
      if ((n_asm_be == 8'd0) || (n_asm_addr == w_word_addr)) begin
        n_asm_addr = w_word_addr;
        n_asm_data = (n_asm_data & ~f_place(16'hFFFF, w_lane)) | f_place(w_word, w_lane);
        n_asm_be   = n_asm_be | f_be(w_lane);
        if (n_asm_be == 8'hFF)
          n_commit = 1'b1;
      end else begin
        n_hold_vld  = 1'b1;
        n_hold_addr = w_word_addr;
        n_hold_lane = w_lane;
        n_hold_word = w_word;
        n_commit    = 1'b1;
      end
    end

    n_wait = (n_commit && (n_wr_req != wr_ack)) || n_hold_vld;
    n_busy = ioctl_download || (r_asm_be != 8'd0) || r_commit || r_hold_vld || (r_wr_req != wr_ack);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_asm_addr  <= '0;
      r_asm_data  <= '0;
      r_asm_be    <= '0;
      r_commit    <= 1'b0;
      r_hold_vld  <= 1'b0;
      r_hold_addr <= '0;
      r_hold_lane <= '0;
      r_hold_word <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_wr_be     <= '0;
      r_wr_req    <= 1'b0;
      r_rom_size  <= '0;
      r_wait      <= 1'b0;
      r_busy      <= 1'b0;
      r_dl_d      <= 1'b0;
    end else begin
      r_asm_addr  <= n_asm_addr;
      r_asm_data  <= n_asm_data;
      r_asm_be    <= n_asm_be;
      r_commit    <= n_commit;
      r_hold_vld  <= n_hold_vld;
      r_hold_addr <= n_hold_addr;
      r_hold_lane <= n_hold_lane;
      r_hold_word <= n_hold_word;
      r_wr_addr   <= n_wr_addr;
      r_wr_data   <= n_wr_data;
      r_wr_be     <= n_wr_be;
      r_wr_req    <= n_wr_req;
      r_rom_size  <= n_rom_size;
      r_wait      <= n_wait;
      r_busy      <= n_busy;
      r_dl_d      <= ioctl_download;
    end
  end

  assign ioctl_wait = r_wait;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign wr_be      = r_wr_be;
  assign wr_req     = r_wr_req;
  assign rom_size   = r_rom_size;
  assign busy       = r_busy;

endmodule

// File: tb/tb_rom_wr_packer.sv
module tb_rom_wr_packer;
  localparam int AW = 25;

  typedef struct packed {
    logic [AW-4:0] a;
    logic [63:0]   d;
    logic [7:0]    be;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          ioctl_download;
  logic          ioctl_wr;
  logic [AW-1:0] ioctl_addr;
  logic [15:0]   ioctl_data;
  logic          ioctl_wait;
  logic [AW-4:0] wr_addr;
  logic [63:0]   wr_data;
  logic [7:0]    wr_be;
  logic          wr_req;
  logic          wr_ack;
  logic [AW-1:0] rom_size;
  logic          busy;

  logic          ioctl_wait1;
  logic [AW-4:0] wr_addr1;
  logic [63:0]   wr_data1;
  logic [7:0]    wr_be1;
  logic          wr_req1;
  logic          wr_ack1;
  logic [AW-1:0] rom_size1;
  logic          busy1;

  always #5 clk = ~clk;

  rom_wr_packer #(.AW(AW), .SWAP(1'b1)) dut (
    .clk_sys(clk), .reset_n(reset_n), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wait(ioctl_wait),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .wr_req(wr_req), .wr_ack(wr_ack),
    .rom_size(rom_size), .busy(busy)
  );

  rom_wr_packer #(.AW(AW), .SWAP(1'b0)) dut_noswap (
    .clk_sys(clk), .reset_n(reset_n), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wait(ioctl_wait1),
    .wr_addr(wr_addr1), .wr_data(wr_data1), .wr_be(wr_be1), .wr_req(wr_req1), .wr_ack(wr_ack1),
    .rom_size(rom_size1), .busy(busy1)
  );

  // ddram models: configurable ack delay for the main instance, fixed for the other
  int ack_delay = 1;
  int ack_cnt;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ack  <= 1'b0;
      ack_cnt <= 0;
    end else if (wr_req != wr_ack) begin
      if (ack_cnt >= ack_delay) begin
        wr_ack  <= wr_req;
        ack_cnt <= 0;
      end else begin
        ack_cnt <= ack_cnt + 1;
      end
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) wr_ack1 <= 1'b0;
    else          wr_ack1 <= wr_req1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: bytes grouped by 64-bit word; a word leaves when full,
  // when a different word address shows up, or when the download ends.
  wr_t exp_q[$];
  wr_t cur;
  int  model_rom;

  task automatic model_word(input logic [AW-1:0] a, input logic [15:0] d);
    int lane;
    lane = int'(a[2:1]);
    if (cur.be != 8'd0 && cur.a != a[AW-1:3]) begin
      exp_q.push_back(cur);
      cur = '0;
    end
    cur.a = a[AW-1:3];
    cur.d[8*(2*lane)   +: 8] = d[15:8];
    cur.d[8*(2*lane+1) +: 8] = d[7:0];
    cur.be[2*lane]   = 1'b1;
    cur.be[2*lane+1] = 1'b1;
    if (cur.be == 8'hFF) begin
      exp_q.push_back(cur);
      cur = '0;
    end
    if (int'(a) + 2 > model_rom) model_rom = int'(a) + 2;
  endtask

  task automatic model_end();
    if (cur.be != 8'd0) exp_q.push_back(cur);
    cur = '0;
  endtask

  // Monitor: compares every presented write against the scoreboard
  logic          prev_req = 1'b0, prev_req1 = 1'b0, prev_ack = 1'b0, prev_busy = 1'b0;
  int            cyc = 0, ack_cyc = 0, fall_cyc = 0, n_writes = 0;
  logic          wait_seen = 1'b0;
  logic [AW-4:0] last_a;
  logic [63:0]   last_d, last1_d;
  logic [7:0]    last_be, last1_be;

  always @(negedge clk) begin
    wr_t e;
    cyc++;
    if (!reset_n) begin
      prev_req  = 1'b0;
      prev_req1 = 1'b0;
    end else begin
      if (ioctl_wait) wait_seen = 1'b1;
      if (wr_ack != prev_ack) ack_cyc = cyc;
      if (prev_busy && !busy) fall_cyc = cyc;
      if (wr_req != prev_req) begin
        n_writes++;
        last_a = wr_addr; last_d = wr_data; last_be = wr_be;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'(wr_addr), 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 64'(wr_addr), 64'(e.a));
          check("wr_data", wr_data, e.d);
          check("wr_be", 64'(wr_be), 64'(e.be));
        end
      end
      if (wr_req1 != prev_req1) begin
        last1_d = wr_data1; last1_be = wr_be1;
      end
      prev_req  = wr_req;
      prev_req1 = wr_req1;
    end
    prev_ack  = wr_ack;
    prev_busy = busy;
  end

  task automatic wr_word(input logic [AW-1:0] a, input logic [15:0] d);
    int guard = 0;
    while (ioctl_wait && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (ioctl_wait) begin
      check("wait_timeout", 64'(ioctl_wait), 64'd0);
    end else begin
      ioctl_wr = 1'b1; ioctl_addr = a; ioctl_data = d;
      model_word(a, d);
      @(posedge clk); #1;
      ioctl_wr = 1'b0;
    end
  endtask

  task automatic start_dl();
    @(posedge clk); #1;
    ioctl_download = 1'b1;
    cur = '0;
    model_rom = 0;
    @(posedge clk); #1;
  endtask

  task automatic end_dl();
    int guard = 0;
    ioctl_download = 1'b0;
    model_end();
    @(posedge clk); #1;
    while (busy && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
    end
    check("busy_drop", 64'(busy), 64'd0);
    @(negedge clk); #1;
    check("drain", 64'(exp_q.size()), 64'd0);
    check("rom_size", 64'(rom_size), 64'(model_rom));
  endtask

  initial begin
    int w0;
    logic [AW-1:0] a;
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_data = '0;
    cur = '0; model_rom = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wait", 64'(ioctl_wait), 64'd0);
    check("rst_req", 64'(wr_req), 64'd0);
    check("rst_be_addr", {wr_be, 31'd0, wr_addr}, 64'd0);
    check("rst_data", wr_data, 64'd0);
    check("rst_size_busy", {rom_size, 31'd0, busy}, 64'd0);
    reset_n = 1'b1;

    // Four sequential words, fast ack
    ack_delay = 1; wait_seen = 1'b0; w0 = n_writes;
    start_dl();
    wr_word(25'd0, 16'h1122); wr_word(25'd2, 16'h3344);
    wr_word(25'd4, 16'h5566); wr_word(25'd6, 16'h7788);
    end_dl();
    check("t1_count", 64'(n_writes - w0), 64'd1);
    check("t1_data", last_d, 64'h8877_6655_4433_2211);
    check("t1_be", 64'(last_be), 64'hFF);
    check("t1_size", 64'(rom_size), 64'd8);
    check("t1_no_wait", 64'(wait_seen), 64'd0);

    // 16 sequential words, slow ack -> stalls
    ack_delay = 20; wait_seen = 1'b0; w0 = n_writes;
    start_dl();
    for (int i = 0; i < 16; i++) wr_word(AW'(2 * i), 16'($urandom));
    end_dl();
    check("t2_count", 64'(n_writes - w0), 64'd4);
    check("t2_wait_seen", 64'(wait_seen), 64'd1);

    // Three words then download end -> partial flush
    ack_delay = 1; w0 = n_writes;
    start_dl();
    wr_word(25'd0, 16'hA001); wr_word(25'd2, 16'hA002); wr_word(25'd4, 16'hA003);
    end_dl();
    check("t3_count", 64'(n_writes - w0), 64'd1);
    check("t3_be", 64'(last_be), 64'h3F);
    check("t3_size", 64'(rom_size), 64'd6);
    check("t3_busy_after_ack", 64'(fall_cyc - ack_cyc), 64'd1);

    // Non-contiguous words
    w0 = n_writes;
    start_dl();
    wr_word(25'd0, 16'hBEEF); wr_word(25'h40, 16'hCAFE);
    end_dl();
    check("t4_count", 64'(n_writes - w0), 64'd2);
    check("t4_addr", 64'(last_a), 64'd8);
    check("t4_be", 64'(last_be), 64'h03);

    // Pass-through byte order
    start_dl();
    wr_word(25'd2, 16'hABCD);
    end_dl();
    check("noswap_data", 64'(last1_d[31:16]), 64'hABCD);
    check("noswap_be", 64'(last1_be), 64'h0C);

    // Randomized downloads
    for (int dl = 0; dl < 3; dl++) begin
      ack_delay = int'($urandom_range(1, 6));
      a = '0;
      start_dl();
      for (int i = 0; i < 40; i++) begin
        if ($urandom_range(0, 1) == 0) a = AW'(2 * $urandom_range(0, 23));
        else                           a = a + AW'(2);
        wr_word(a, 16'($urandom));
        repeat ($urandom_range(0, 2)) @(posedge clk);
      end
      end_dl();
    end

    // Asynchronous reset mid-stall
    ack_delay = 50;
    start_dl();
    for (int i = 0; i < 8; i++) wr_word(AW'(2 * i), 16'(i + 1));
    check("stall_wait", 64'(ioctl_wait), 64'd1);
    check("stall_outstanding", 64'(wr_req ^ wr_ack), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_wait_req", {62'd0, ioctl_wait, wr_req}, 64'd0);
    check("arst_be_addr", {wr_be, 31'd0, wr_addr}, 64'd0);
    check("arst_data", wr_data, 64'd0);
    check("arst_size_busy", {rom_size, 31'd0, busy}, 64'd0);
    exp_q.delete();
    cur = '0;
    ioctl_download = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    ack_delay = 1;
    start_dl();
    check("post_rst_size", 64'(rom_size), 64'd0);
    for (int i = 0; i < 4; i++) wr_word(AW'(16 + 2 * i), 16'($urandom));
    end_dl();
    check("post_rst_addr", 64'(last_a), 64'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
